// File: rtl/cgol_pkg.sv
// cgol_pkg: state and memory-mux encodings plus memory operation codes
// shared by the frame sequencer and memory_controller.
package cgol_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEED_OUT = 3'd1,
    S_COMPUTE  = 3'd2,
    S_COMMIT   = 3'd3,
    S_OUTPUT   = 3'd4,
    S_PAUSE    = 3'd5
  } state_e;
  typedef enum logic [1:0] {
    MUX_CGOL   = 2'd0,
    MUX_COMMIT = 2'd1,
    MUX_OUTPUT = 2'd2,
    MUX_IDLE   = 2'd3
  } mux_sel_e;
  localparam logic [1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [1:0] MEM_OP_READ  = 2'd1;
  localparam logic [1:0] MEM_OP_WRITE = 2'd2;
  localparam logic [1:0] MEM_OP_SWAP  = 2'd3;
  function automatic mux_sel_e mux_of(state_e s);
    return s == S_COMPUTE ? MUX_CGOL :
           s == S_COMMIT  ? MUX_COMMIT :
           (s == S_SEED_OUT || s == S_OUTPUT) ? MUX_OUTPUT : MUX_IDLE;
  endfunction
endpackage

// File: rtl/cgol_commit_walker.sv
// cgol_commit_walker: walks commit addresses 0..NUM_CELLS-1, holding each for
// COMMIT_CLK_CYCLES cycles; strobe on the last hold cycle, last on the final strobe.
module cgol_commit_walker
  import cgol_pkg::*;
#(
  parameter int NUM_CELLS         = 64,
  parameter int COMMIT_CLK_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  output logic [$clog2(NUM_CELLS)-1:0] addr_o,
  output logic                         stb_o,
  output logic                         last_o
);
  localparam int AW = $clog2(NUM_CELLS);
  localparam int HW = COMMIT_CLK_CYCLES > 1 ? $clog2(COMMIT_CLK_CYCLES) : 1;
  logic [HW-1:0] hold_q;
  logic [AW-1:0] addr_q;
  assign stb_o  = en_i && hold_q == HW'(COMMIT_CLK_CYCLES - 1);
  assign last_o = stb_o && addr_q == AW'(NUM_CELLS - 1);
  assign addr_o = addr_q;
  // Counters return to zero after the final strobe, so the next walk starts clean.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      addr_q <= '0;
    end else if (stb_o) begin
      hold_q <= '0;
      addr_q <= last_o ? '0 : addr_q + 1'b1;
    end else if (en_i) begin
      hold_q <= hold_q + 1'b1;
    end
endmodule

// File: rtl/cgol_frame_sequencer.sv
// cgol_frame_sequencer: COMPUTE -> COMMIT -> OUTPUT -> PAUSE generation loop with
// run/step control and seed display; CGOL_SEQ_WATCHDOG_EN adds a phase watchdog.
module cgol_frame_sequencer
  import cgol_pkg::*;
#(
  parameter int NUM_CH            = 3,
  parameter int NUM_CELLS         = 64,
  parameter int COMMIT_CLK_CYCLES = 4,
  parameter int PAUSE_CLK_CYCLES  = 1200000,
  parameter int GEN_W             = 16,
  parameter int WDT_CYCLES        = 65536
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_run,
  input  logic                         i_step,
  output logic [NUM_CH-1:0]            o_cgol_start,
  input  logic [NUM_CH-1:0]            i_cgol_done,
  output logic [1:0]                   o_mem_sel,
  output logic [$clog2(NUM_CELLS)-1:0] o_commit_addr,
  output logic                         o_commit_stb,
  output logic                         o_out_start,
  input  logic                         i_out_done,
  output logic [2:0]                   o_state,
  output logic [GEN_W-1:0]             o_gen_count,
  output logic                         o_busy,
  output logic                         o_fault
);
  localparam int PW = $clog2(PAUSE_CLK_CYCLES + 1);
  state_e            state_q;
  mux_sel_e          mem_sel_q;
  logic [NUM_CH-1:0] done_q, done_d, cgol_start_q;
  logic [PW-1:0]     pause_q;
  logic [GEN_W-1:0]  gen_q;
  logic              run_q, out_start_q, wdt_hit, walk_last;

  cgol_commit_walker #(
    .NUM_CELLS(NUM_CELLS),
    .COMMIT_CLK_CYCLES(COMMIT_CLK_CYCLES)
  ) u_walker (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(state_q == S_COMMIT),
    .addr_o(o_commit_addr),
    .stb_o(o_commit_stb),
    .last_o(walk_last)
  );

  assign done_d = done_q | i_cgol_done;

  // Right after reset the state is SEED_OUT but the mux is still IDLE; that pair marks the seed start cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= S_SEED_OUT;
      mem_sel_q    <= MUX_IDLE;
      done_q       <= '0;
      cgol_start_q <= '0;
      pause_q      <= '0;
      gen_q        <= '0;
      run_q        <= 1'b0;
      out_start_q  <= 1'b0;
    end else begin
      out_start_q  <= 1'b0;
      cgol_start_q <= '0;
      if (wdt_hit) begin
        state_q   <= S_IDLE;
        mem_sel_q <= mux_of(S_IDLE);
        done_q    <= '0;
        run_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE:
            if (i_run) begin
              state_q   <= S_PAUSE;
              mem_sel_q <= mux_of(S_PAUSE);
              run_q     <= 1'b1;
            end else if (i_step) begin
              state_q      <= S_COMPUTE;
              mem_sel_q    <= mux_of(S_COMPUTE);
              cgol_start_q <= '1;
              run_q        <= 1'b0;
            end
          S_SEED_OUT:
            if (mem_sel_q == MUX_IDLE) begin
              out_start_q <= 1'b1;
              mem_sel_q   <= mux_of(S_SEED_OUT);
            end else if (i_out_done) begin
              state_q   <= S_PAUSE;
              mem_sel_q <= mux_of(S_PAUSE);
            end
          S_COMPUTE:
            if (&done_d) begin
              done_q    <= '0;
              state_q   <= S_COMMIT;
              mem_sel_q <= mux_of(S_COMMIT);
            end else begin
              done_q <= done_d;
            end
          S_COMMIT:
            if (walk_last) begin
              gen_q       <= gen_q + 1'b1;
              state_q     <= S_OUTPUT;
              mem_sel_q   <= mux_of(S_OUTPUT);
              out_start_q <= 1'b1;
            end
          S_OUTPUT:
            if (i_out_done) begin
              state_q   <= run_q ? S_PAUSE : S_IDLE;
              mem_sel_q <= mux_of(run_q ? S_PAUSE : S_IDLE);
            end
          S_PAUSE:
            if (pause_q == PW'(PAUSE_CLK_CYCLES - 1)) begin
              pause_q      <= '0;
              run_q        <= i_run;
              state_q      <= i_run ? S_COMPUTE : S_IDLE;
              mem_sel_q    <= mux_of(i_run ? S_COMPUTE : S_IDLE);
              cgol_start_q <= {NUM_CH{i_run}};
            end else begin
              pause_q <= pause_q + 1'b1;
            end
          default: begin
            state_q   <= S_IDLE;
            mem_sel_q <= mux_of(S_IDLE);
          end
        endcase
      end
    end

`ifdef CGOL_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_q;
  logic          fault_q, waiting;
  // Waiting states never follow one another directly, so the counter is already zero on entry.
  assign waiting = state_q == S_COMPUTE || state_q == S_SEED_OUT || state_q == S_OUTPUT;
  assign wdt_hit = waiting && wdt_q == WW'(WDT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wdt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      wdt_q   <= waiting ? wdt_q + 1'b1 : '0;
      fault_q <= wdt_hit;
    end
  assign o_fault = fault_q;
`else
  assign wdt_hit = 1'b0;
  // WDT_CYCLES has no effect in this build; the expression is constant zero.
  assign o_fault = WDT_CYCLES < 0;
`endif

  assign o_cgol_start = cgol_start_q;
  assign o_out_start  = out_start_q;
  assign o_mem_sel    = mem_sel_q;
  assign o_state      = state_q;
  assign o_gen_count  = gen_q;
  assign o_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_cgol_frame_sequencer.sv
// tb_cgol_frame_sequencer: scoreboard bench for cgol_frame_sequencer;
// CGOL_SEQ_WATCHDOG_EN selects the watchdog expectations in the last scenario.
module tb_cgol_frame_sequencer;
  import cgol_pkg::*;
  localparam int NCH = 3, CELLS = 4, CMT = 2, PAUSE = 4, GW = 16, WDT = 16;

  logic clk = 1'b0, rst_n = 1'b1, i_run = 1'b0, i_step = 1'b0, i_out_done = 1'b0;
  logic [NCH-1:0] i_cgol_done = '0, o_cgol_start;
  logic [1:0] o_mem_sel, o_commit_addr;
  logic o_commit_stb, o_out_start, o_busy, o_fault;
  logic [2:0] o_state;
  logic [GW-1:0] o_gen_count;
  int cyc, n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic os; logic [2:0] cg; logic stb; logic flt;
    logic [2:0] st; logic [1:0] mux; logic [1:0] addr; logic [15:0] gen;
  } obs_t;
  typedef struct { int c; obs_t o; } exp_t;
  exp_t q[$];
  obs_t cur;

  cgol_frame_sequencer #(
    .NUM_CH(NCH), .NUM_CELLS(CELLS), .COMMIT_CLK_CYCLES(CMT),
    .PAUSE_CLK_CYCLES(PAUSE), .GEN_W(GW), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_step(i_step),
    .o_cgol_start(o_cgol_start), .i_cgol_done(i_cgol_done), .o_mem_sel(o_mem_sel),
    .o_commit_addr(o_commit_addr), .o_commit_stb(o_commit_stb), .o_out_start(o_out_start),
    .i_out_done(i_out_done), .o_state(o_state), .o_gen_count(o_gen_count),
    .o_busy(o_busy), .o_fault(o_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  assign cur = {o_out_start, o_cgol_start, o_commit_stb, o_fault, o_state, o_mem_sel, o_commit_addr, o_gen_count};

  task automatic ev(int c, logic os, logic [2:0] cg, logic stb, logic flt,
                    logic [2:0] st, logic [1:0] mux, logic [1:0] addr, logic [15:0] gen);
    exp_t e;
    e.c = c;
    e.o = {os, cg, stb, flt, st, mux, addr, gen};
    q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_state"}, o_state, 3'd1);
    chk({tag, "_mux"}, o_mem_sel, 2'd3);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_out_start"}, o_out_start, 0);
    chk({tag, "_cgol_start"}, o_cgol_start, 0);
    chk({tag, "_stb"}, o_commit_stb, 0);
    chk({tag, "_addr"}, o_commit_addr, 0);
    chk({tag, "_gen"}, o_gen_count, 0);
    chk({tag, "_fault"}, o_fault, 0);
  endtask

  task automatic at(int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic pulse_out(int n);
    at(n); i_out_done = 1'b1; @(negedge clk); i_out_done = 1'b0;
  endtask
  task automatic pulse_step(int n);
    at(n); i_step = 1'b1; @(negedge clk); i_step = 1'b0;
  endtask
  task automatic pulse_cg(int n, logic [2:0] v);
    at(n); i_cgol_done = v; @(negedge clk); i_cgol_done = '0;
  endtask

  // Monitor: every pulse the DUT emits must match the next scoreboard entry, cycle included.
  initial forever begin
    @(negedge clk);
    if (rst_n && (o_out_start || |o_cgol_start || o_commit_stb || o_fault)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.c != cyc || e.o !== cur) begin
          n_fail++;
          $display("FAIL event got=%h@%0d want=%h@%0d", cur, cyc, e.o, e.c);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset("rst0");
    repeat (2) @(negedge clk);
    // seed display, then run-mode generation, then step-mode generation, then a run generation cut by reset
    ev(1,  1, 3'b000, 0, 0, 3'd1, 2'd2, 2'd0, 16'd0);
    ev(7,  0, 3'b111, 0, 0, 3'd2, 2'd0, 2'd0, 16'd0);
    ev(18, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd0, 16'd0);
    ev(20, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd1, 16'd0);
    ev(22, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd2, 16'd0);
    ev(24, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd3, 16'd0);
    ev(25, 1, 3'b000, 0, 0, 3'd4, 2'd2, 2'd0, 16'd1);
    ev(35, 0, 3'b111, 0, 0, 3'd2, 2'd0, 2'd0, 16'd1);
    ev(37, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd0, 16'd1);
    ev(39, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd1, 16'd1);
    ev(41, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd2, 16'd1);
    ev(43, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd3, 16'd1);
    ev(44, 1, 3'b000, 0, 0, 3'd4, 2'd2, 2'd0, 16'd2);
    ev(53, 0, 3'b111, 0, 0, 3'd2, 2'd0, 2'd0, 16'd2);
    ev(59, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd0, 16'd2);
    ev(61, 0, 3'b000, 1, 0, 3'd3, 2'd1, 2'd1, 16'd2);
    rst_n = 1'b1;
    i_run = 1'b1;
    pulse_out(2);
    at(6);  chk("pause_hold", o_state, 3'd5);
    at(7);  chk("pause_exit", o_state, 3'd2);
    pulse_cg(9, 3'b001);
    pulse_out(10);
    pulse_cg(12, 3'b100);
    pulse_cg(13, 3'b001);
    at(16); chk("compute_wait", o_state, 3'd2);
    pulse_cg(16, 3'b010);
    chk("commit_entry", o_state, 3'd3);
    at(19); i_run = 1'b0;
    pulse_out(27);
    pulse_step(29);
    at(31); chk("pause_busy", o_busy, 1);
    chk("pause_after_gen", o_state, 3'd5);
    at(32); chk("idle_state", o_state, 3'd0);
    chk("idle_busy", o_busy, 0);
    chk("idle_mux", o_mem_sel, 2'd3);
    chk("gen_one", o_gen_count, 1);
    pulse_step(34);
    pulse_cg(35, 3'b111);
    pulse_out(45);
    chk("step_idle", o_state, 3'd0);
    chk("step_gen", o_gen_count, 2);
    chk("step_busy", o_busy, 0);
    at(48); i_run = 1'b1; i_step = 1'b1; i_cgol_done = 3'b011;
    @(negedge clk); i_step = 1'b0; i_cgol_done = '0;
    chk("run_priority", o_state, 3'd5);
    at(52); chk("pause_len", o_state, 3'd5);
    pulse_cg(55, 3'b100);
    at(57); chk("stray_done_ignored", o_state, 3'd2);
    pulse_cg(57, 3'b011);
    chk("commit_entry2", o_state, 3'd3);
    at(61);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    chk("drain1", q.size(), 0);
    i_run = 1'b0;
    repeat (2) @(negedge clk);
    // seed, pause into idle, one step with channel 2 withheld
    ev(1, 1, 3'b000, 0, 0, 3'd1, 2'd2, 2'd0, 16'd0);
    ev(9, 0, 3'b111, 0, 0, 3'd2, 2'd0, 2'd0, 16'd0);
`ifdef CGOL_SEQ_WATCHDOG_EN
    ev(25, 0, 3'b000, 0, 1, 3'd0, 2'd3, 2'd0, 16'd0);
`endif
    rst_n = 1'b1;
    pulse_out(2);
    at(7); chk("idle_after_seed", o_state, 3'd0);
    pulse_step(8);
    pulse_cg(10, 3'b011);
    at(24); chk("wdt_not_yet", o_state, 3'd2);
    at(26);
`ifdef CGOL_SEQ_WATCHDOG_EN
    chk("wdt_idle", o_state, 3'd0);
    chk("wdt_busy", o_busy, 0);
`else
    chk("no_wdt_waits", o_state, 3'd2);
`endif
    chk("fault_low", o_fault, 0);
    at(28);
    chk("drain2", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cgol_frame_sequencer.md
Name: cgol_frame_sequencer

Overview:
Parametrised generation sequencer for the Game of Life LED-matrix design. It drives N compute channels (cgol_logic + memory_controller pairs) and one output_controller through a COMPUTE -> COMMIT -> OUTPUT -> PAUSE loop. It owns the memory-port mux select and the commit address walk. Beyond a fixed free-running loop, it adds run/stop, single-step, multi-channel done aggregation, a seed display after reset and a generation counter.

Parameters:
NUM_CH, 3, number of compute channels (1..8)
NUM_CELLS, 64, cells per board; commit address walk length (power of 2 not required)
COMMIT_CLK_CYCLES, 4, cycles each commit address is held (>=1)
PAUSE_CLK_CYCLES, 1200000, cycles spent in PAUSE (>=1); 0.1 s at 12 MHz
GEN_W, 16, generation counter width
WDT_CYCLES, 65536, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
i_run  in  1  level; 1 = free-run generations
i_step  in  1  one-cycle pulse; run one generation while idle
o_cgol_start  out  NUM_CH  one-cycle start pulse per channel
i_cgol_done  in  NUM_CH  per-channel done pulse
o_mem_sel  out  2  memory mux select (MUX_CGOL / MUX_COMMIT / MUX_OUTPUT / MUX_IDLE)
o_commit_addr  out  $clog2(NUM_CELLS)  cell address being committed
o_commit_stb  out  1  commit strobe, last cycle of each address hold
o_out_start  out  1  one-cycle start pulse to output_controller
i_out_done  in  1  output_controller done pulse
o_state  out  3  current state encoding, for debug
o_gen_count  out  GEN_W  completed generations
o_busy  out  1  high in every state except S_IDLE
o_fault  out  1  watchdog fault pulse; tied 0 without the optional feature

Behaviour:
- Reset (async, rst_n=0) values:
  - state = S_SEED_OUT
  - all counters and done bits = 0
  - o_cgol_start = 0, o_out_start = 0, o_commit_stb = 0, o_commit_addr = 0, o_gen_count = 0, o_fault = 0
  - o_mem_sel = MUX_IDLE
  - o_busy = 1
- States and mux selects:
  - S_IDLE: MUX_IDLE
  - S_SEED_OUT: MUX_OUTPUT
  - S_COMPUTE: MUX_CGOL
  - S_COMMIT: MUX_COMMIT
  - S_OUTPUT: MUX_OUTPUT
  - S_PAUSE: MUX_IDLE
- o_mem_sel is registered and changes in the same cycle as the state.
- Start pulses: o_out_start pulses for exactly the first cycle after entering S_SEED_OUT or S_OUTPUT. o_cgol_start = all ones for exactly the first cycle after entering S_COMPUTE.
- S_SEED_OUT: on i_out_done -> S_PAUSE. This displays the seed once after reset.
- S_COMPUTE:
  - Keep a sticky done vector; set bit k when i_cgol_done[k]=1.
  - Multiple bits may set in the same cycle.
  - When the vector, including bits set this cycle, is all ones -> clear it and go to S_COMMIT.
  - A done pulse arriving in the start cycle is honoured.
- S_COMMIT:
  - Hold each address for COMMIT_CLK_CYCLES cycles; o_commit_stb=1 on the last of them.
  - After address NUM_CELLS-1 strobes: o_gen_count += 1 (wraps at 2^GEN_W), then -> S_OUTPUT.
  - Total duration is exactly NUM_CELLS*COMMIT_CLK_CYCLES cycles.
- S_OUTPUT: on i_out_done -> S_PAUSE if run mode, else S_IDLE (step mode).
- S_PAUSE:
  - Lasts exactly PAUSE_CLK_CYCLES cycles.
  - On exit: i_run=1 -> S_COMPUTE; i_run=0 -> S_IDLE.
- S_IDLE:
  - i_run=1 -> S_PAUSE (run mode).
  - Else i_step=1 -> S_COMPUTE (step mode); i_run has priority.
  - i_step outside S_IDLE is ignored.
- i_run dropping mid-generation never aborts a phase; it is sampled only in S_IDLE and at PAUSE exit.
- i_cgol_done outside S_COMPUTE and i_out_done outside the two output states are ignored and do not set sticky state.
- Reset mid-operation: immediate return to reset values. Channel modules are not this block's responsibility.

Optional Feature:
Macro CGOL_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in S_COMPUTE, S_SEED_OUT and S_OUTPUT, cleared on state entry.
  - Reaching WDT_CYCLES -> o_fault pulses for 1 cycle, the sticky done vector clears, state -> S_IDLE, run mode cleared.
- Undefined: no counter; o_fault tied 0; phases may wait forever.

Decomposition:
- Package cgol_pkg holds:
  - state enum (S_IDLE=0, S_SEED_OUT, S_COMPUTE, S_COMMIT, S_OUTPUT, S_PAUSE)
  - mux select enum (MUX_CGOL=0, MUX_COMMIT=1, MUX_OUTPUT=2, MUX_IDLE=3)
  - the memory operation constants shared with memory_controller
- One natural sub-module: cgol_commit_walker (address/hold counters, strobe, last flag), instantiated once.

Test Plan:
- Reset, i_run=1, PAUSE=4, NUM_CELLS=4, COMMIT=2: o_out_start at cycle 1 -> i_out_done -> pause 4 cycles -> o_cgol_start=3'b111, o_mem_sel=MUX_CGOL.
- Channel dones at different cycles (ch0@+2, ch2@+5, ch1@+9): S_COMMIT entered the cycle after ch1; a repeat ch0 done is harmless.
- Commit walk: exactly 8 cycles; addresses 0,0,1,1,2,2,3,3; strobes on odd cycles; o_gen_count 0->1, then o_out_start.
- i_run=0 during S_COMMIT: generation completes, PAUSE runs, then S_IDLE with o_busy=0. i_step pulse -> one generation -> S_IDLE, gen+1.
- Simultaneous i_run=1 and i_step in S_IDLE -> S_PAUSE. Stray i_out_done in S_COMPUTE ignored. rst_n low mid-commit -> all outputs at reset values asynchronously.
- With CGOL_SEQ_WATCHDOG_EN and WDT_CYCLES=16, withhold ch2 done: o_fault pulse at cycle 16 of S_COMPUTE, state S_IDLE.
